// File: rtl/crc_stream.sv
// Streaming CRC engine: passes framed valid/ready beats through a 1-entry output register and
// either appends a CRC beat to each frame (CHECK=0) or checks each frame's final beat (CHECK=1).
module crc_stream #(
    parameter int unsigned           DATA_W = 32,
    parameter int unsigned           CRC_W  = 8,
    parameter logic [CRC_W-1:0]      POLY   = 8'h31,
    parameter logic [CRC_W-1:0]      INIT   = {CRC_W{1'b0}},
    parameter logic [CRC_W-1:0]      XOROUT = {CRC_W{1'b0}},
    parameter bit                    CHECK  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              crc_done,
    output logic              crc_err,
    output logic [15:0]       err_cnt
);

    typedef enum logic [0:0] {
        S_DATA = 1'b0,
        S_CRC  = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [CRC_W-1:0]    crc_r;
    logic                first_r;
    logic                m_valid_r;
    logic [DATA_W-1:0]   m_data_r;
    logic                m_last_r;
    logic                crc_done_r;
    logic                crc_err_r;
    logic [15:0]         err_cnt_r;

    logic                out_free_s;
    logic                s_ready_s;
    logic                accept_s;
    logic                load_crc_s;
    logic [CRC_W-1:0]    crc_base_s;
    logic [CRC_W-1:0]    crc_next_s;
    logic [CRC_W-1:0]    crc_gen_final_s;
    logic [CRC_W-1:0]    crc_chk_final_s;
    logic                mismatch_s;
    logic [DATA_W-1:0]   crc_beat_s;

    // MSB-first, non-reflected LFSR over a whole beat
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc_in,
                                                  input logic [DATA_W-1:0] data);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc_in;
        for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ data[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});
        end
        return c;
    endfunction

    // The first beat of a frame always starts from INIT, never from a stale register
    assign crc_base_s      = first_r ? INIT : crc_r;
    assign crc_next_s      = crc_step(crc_base_s, s_data);
    assign crc_gen_final_s = crc_r ^ XOROUT;
    assign crc_chk_final_s = crc_base_s ^ XOROUT;
    assign mismatch_s      = (s_data[CRC_W-1:0] != crc_chk_final_s);
    assign out_free_s      = !m_valid_r || m_ready;

    // Zero-extend the final CRC into a full output beat
    always_comb begin
        crc_beat_s              = {DATA_W{1'b0}};
        crc_beat_s[CRC_W-1:0]   = crc_gen_final_s;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_DATA;
        end else if (clear) begin
            state_r <= S_DATA;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; checker mode never leaves S_DATA
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_DATA: begin
                if (accept_s && s_last && !CHECK) state_nx_s = S_CRC;
                else                              state_nx_s = S_DATA;
            end
            S_CRC: begin
                if (out_free_s) state_nx_s = S_DATA;
                else            state_nx_s = S_CRC;
            end
            default: state_nx_s = S_DATA;
        endcase
    end

    // FSM outputs: input handshake and CRC-beat load strobe
    always_comb begin
        s_ready_s  = 1'b0;
        load_crc_s = 1'b0;
        case (state_r)
            S_DATA: begin
                s_ready_s  = out_free_s;
                load_crc_s = 1'b0;
            end
            S_CRC: begin
                s_ready_s  = 1'b0;
                load_crc_s = out_free_s;
            end
            default: begin
                s_ready_s  = 1'b0;
                load_crc_s = 1'b0;
            end
        endcase
    end

    assign accept_s = s_valid && s_ready_s;

    // Datapath: CRC accumulation, output register and check results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_r      <= INIT;
            first_r    <= 1'b1;
            m_valid_r  <= 1'b0;
            m_data_r   <= {DATA_W{1'b0}};
            m_last_r   <= 1'b0;
            crc_done_r <= 1'b0;
            crc_err_r  <= 1'b0;
            err_cnt_r  <= 16'h0000;
        end else if (clear) begin
            crc_r      <= INIT;
            first_r    <= 1'b1;
            m_valid_r  <= 1'b0;
            m_last_r   <= 1'b0;
            crc_done_r <= 1'b0;
            crc_err_r  <= 1'b0;
        end else begin
            crc_done_r <= 1'b0;
            crc_err_r  <= 1'b0;
            if (accept_s) begin
                m_valid_r <= 1'b1;
                m_data_r  <= s_data;
                m_last_r  <= CHECK ? s_last : 1'b0;
                if (CHECK && s_last) begin
                    crc_r      <= INIT;
                    first_r    <= 1'b1;
                    crc_done_r <= 1'b1;
                    crc_err_r  <= mismatch_s;
                    if (mismatch_s && (err_cnt_r != 16'hFFFF)) err_cnt_r <= err_cnt_r + 16'd1;
                end else begin
                    crc_r   <= crc_next_s;
                    first_r <= 1'b0;
                end
            end else if (load_crc_s) begin
                m_valid_r <= 1'b1;
                m_data_r  <= crc_beat_s;
                m_last_r  <= 1'b1;
                crc_r     <= INIT;
                first_r   <= 1'b1;
            end else if (m_ready) begin
                m_valid_r <= 1'b0;
            end else begin
                m_valid_r <= m_valid_r;
            end
        end
    end

    assign s_ready  = s_ready_s;
    assign m_valid  = m_valid_r;
    assign m_data   = m_data_r;
    assign m_last   = m_last_r;
    assign crc_done = crc_done_r;
    assign crc_err  = crc_err_r;
    assign err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_crc_stream.sv
// Bench for crc_stream: two generators (INIT 0 and INIT FF) and one checker, all 8-bit beats,
// compared against a polynomial long-division CRC model.
module tb_crc_stream;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       g_clear, g_s_valid, g_s_ready, g_s_last, g_m_valid, g_m_ready, g_m_last, g_crc_done, g_crc_err;
    logic [7:0] g_s_data, g_m_data;
    logic [15:0] g_err_cnt;
    logic       f_clear, f_s_valid, f_s_ready, f_s_last, f_m_valid, f_m_ready, f_m_last, f_crc_done, f_crc_err;
    logic [7:0] f_s_data, f_m_data;
    logic [15:0] f_err_cnt;
    logic       c_clear, c_s_valid, c_s_ready, c_s_last, c_m_valid, c_m_ready, c_m_last, c_crc_done, c_crc_err;
    logic [7:0] c_s_data, c_m_data;
    logic [15:0] c_err_cnt;

    crc_stream #(.DATA_W(8), .CRC_W(8), .POLY(8'h31), .INIT(8'h00), .XOROUT(8'h00), .CHECK(1'b0)) u_gen (
        .clk(clk), .rst_n(rst_n), .clear(g_clear), .s_valid(g_s_valid), .s_ready(g_s_ready),
        .s_data(g_s_data), .s_last(g_s_last), .m_valid(g_m_valid), .m_ready(g_m_ready),
        .m_data(g_m_data), .m_last(g_m_last), .crc_done(g_crc_done), .crc_err(g_crc_err), .err_cnt(g_err_cnt));

    crc_stream #(.DATA_W(8), .CRC_W(8), .POLY(8'h31), .INIT(8'hFF), .XOROUT(8'h00), .CHECK(1'b0)) u_genf (
        .clk(clk), .rst_n(rst_n), .clear(f_clear), .s_valid(f_s_valid), .s_ready(f_s_ready),
        .s_data(f_s_data), .s_last(f_s_last), .m_valid(f_m_valid), .m_ready(f_m_ready),
        .m_data(f_m_data), .m_last(f_m_last), .crc_done(f_crc_done), .crc_err(f_crc_err), .err_cnt(f_err_cnt));

    crc_stream #(.DATA_W(8), .CRC_W(8), .POLY(8'h31), .INIT(8'h00), .XOROUT(8'h00), .CHECK(1'b1)) u_chk (
        .clk(clk), .rst_n(rst_n), .clear(c_clear), .s_valid(c_s_valid), .s_ready(c_s_ready),
        .s_data(c_s_data), .s_last(c_s_last), .m_valid(c_m_valid), .m_ready(c_m_ready),
        .m_data(c_m_data), .m_last(c_m_last), .crc_done(c_crc_done), .crc_err(c_crc_err), .err_cnt(c_err_cnt));

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] g_out_q[$], g_exp_q[$], f_out_q[$];
    logic       g_rand = 1'b0;
    logic       g_mon_en = 1'b1;
    logic       g_stall = 1'b0;
    logic [8:0] g_held = 9'h000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: remainder of (M(x) + INIT*x^(len-8)) * x^8 modulo x^8+x^5+x^4+1
    function automatic logic [7:0] ref_crc(input logic [7:0] init, input logic [7:0] beats[$]);
        bit         bits[$];
        logic [8:0] rem;
        if (beats.size() == 0) return init;
        foreach (beats[k]) for (int b = 7; b >= 0; b--) bits.push_back(beats[k][b]);
        for (int b = 0; b < 8; b++) bits[b] = bits[b] ^ init[7-b];
        for (int b = 0; b < 8; b++) bits.push_back(1'b0);
        rem = 9'h000;
        foreach (bits[i]) begin
            rem = {rem[7:0], bits[i]};
            if (rem[8]) rem = rem ^ 9'h131;
        end
        return rem[7:0];
    endfunction

    function automatic logic rdy(input int u);
        case (u)
            0:       return g_s_ready;
            1:       return f_s_ready;
            default: return c_s_ready;
        endcase
    endfunction

    task automatic send(input int u, input logic [7:0] d, input logic last);
        int t = 0;
        case (u)
            0:       begin g_s_valid = 1'b1; g_s_data = d; g_s_last = last; end
            1:       begin f_s_valid = 1'b1; f_s_data = d; f_s_last = last; end
            default: begin c_s_valid = 1'b1; c_s_data = d; c_s_last = last; end
        endcase
        do begin @(negedge clk); t++; end while (!rdy(u) && t < 200);
        if (t >= 200) begin
            n_cmp++; n_err++;
            $error("FAIL accept_timeout unit=%0d observed=no_ready expected=ready", u);
        end
        @(posedge clk); #1;
        case (u)
            0:       g_s_valid = 1'b0;
            1:       f_s_valid = 1'b0;
            default: c_s_valid = 1'b0;
        endcase
    endtask

    task automatic drain();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic g_compare(input string tag);
        check({tag, "_count"}, g_out_q.size(), g_exp_q.size());
        for (int i = 0; i < g_out_q.size() && i < g_exp_q.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), g_out_q[i], g_exp_q[i]);
        g_out_q.delete();
        g_exp_q.delete();
    endtask

    // Randomised downstream back-pressure for the INIT=0 generator
    always @(posedge clk) begin
        #1;
        if (g_rand) g_m_ready = 1'($urandom_range(0, 1));
    end

    // Output monitor: records transfers and checks beats hold while stalled
    always @(negedge clk) begin
        if (g_m_valid && g_m_ready) g_out_q.push_back({g_m_last, g_m_data});
        if (f_m_valid && f_m_ready) f_out_q.push_back({f_m_last, f_m_data});
        if (g_mon_en && g_stall) begin
            check("hold_valid", g_m_valid, 1);
            check("hold_beat", {g_m_last, g_m_data}, g_held);
        end
        g_stall = g_m_valid && !g_m_ready && !g_clear;
        g_held  = {g_m_last, g_m_data};
    end

    initial begin
        logic [7:0] pay[$];
        logic [7:0] crc, last_b;
        logic       bad;
        int         n, exp_err;
        logic [7:0] digits[9];
        digits = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        rst_n = 1'b0;
        g_clear = 1'b0; g_s_valid = 1'b0; g_s_data = 8'h00; g_s_last = 1'b0; g_m_ready = 1'b1;
        f_clear = 1'b0; f_s_valid = 1'b0; f_s_data = 8'h00; f_s_last = 1'b0; f_m_ready = 1'b1;
        c_clear = 1'b0; c_s_valid = 1'b0; c_s_data = 8'h00; c_s_last = 1'b0; c_m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", g_m_valid, 0);
        check("rst_m_data", g_m_data, 0);
        check("rst_m_last", g_m_last, 0);
        check("rst_s_ready", g_s_ready, 1);
        check("rst_crc_done", c_crc_done, 0);
        check("rst_crc_err", c_crc_err, 0);
        check("rst_err_cnt", c_err_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-beat frame 0x01 -> data beat then CRC 0x31
        send(0, 8'h01, 1'b1);
        drain();
        g_exp_q.push_back(9'h001);
        g_exp_q.push_back(9'h131);
        g_compare("t1");

        // "123456789" with INIT=FF -> CRC beat F7
        for (int i = 0; i < 9; i++) send(1, digits[i], (i == 8) ? 1'b1 : 1'b0);
        drain();
        check("t2_count", f_out_q.size(), 10);
        for (int i = 0; i < 9 && i < f_out_q.size(); i++)
            check($sformatf("t2_beat%0d", i), f_out_q[i], {1'b0, digits[i]});
        if (f_out_q.size() >= 10) check("t2_crc_beat", f_out_q[9], 9'h1F7);

        // Checker: good then bad two-beat frames
        send(2, 8'h01, 1'b0);
        send(2, 8'h31, 1'b1);
        check("t3_done_good", c_crc_done, 1);
        check("t3_err_good", c_crc_err, 0);
        check("t3_cnt_good", c_err_cnt, 0);
        check("t3_pass_data", c_m_data, 8'h31);
        check("t3_pass_last", c_m_last, 1);
        send(2, 8'h01, 1'b0);
        send(2, 8'h30, 1'b1);
        check("t3_done_bad", c_crc_done, 1);
        check("t3_err_bad", c_crc_err, 1);
        check("t3_cnt_bad", c_err_cnt, 1);
        @(posedge clk); #1;
        check("t3_done_pulse", c_crc_done, 0);
        exp_err = 1;

        // Random checker frames, some corrupted, sent back to back
        for (int f = 0; f < 8; f++) begin
            pay.delete();
            n = $urandom_range(0, 4);
            for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
            crc = ref_crc(8'h00, pay);
            bad = 1'($urandom_range(0, 1));
            last_b = bad ? (crc ^ (8'h01 << $urandom_range(0, 7))) : crc;
            foreach (pay[i]) send(2, pay[i], 1'b0);
            send(2, last_b, 1'b1);
            if (bad) exp_err++;
            check($sformatf("t4c_done%0d", f), c_crc_done, 1);
            check($sformatf("t4c_err%0d", f), c_crc_err, bad);
            check($sformatf("t4c_cnt%0d", f), c_err_cnt, exp_err);
        end

        // Random back-pressure with back-to-back generator frames
        g_rand = 1'b1;
        for (int f = 0; f < 10; f++) begin
            pay.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
            foreach (pay[i]) begin
                send(0, pay[i], (i == n - 1) ? 1'b1 : 1'b0);
                g_exp_q.push_back({1'b0, pay[i]});
            end
            g_exp_q.push_back({1'b1, ref_crc(8'h00, pay)});
        end
        g_rand = 1'b0;
        @(posedge clk); #2;
        g_m_ready = 1'b1;
        drain();
        g_compare("t4");

        // clear while the CRC beat is pending, then a fresh frame
        g_m_ready = 1'b0;
        send(0, 8'hA5, 1'b1);
        check("t5_pending", g_m_valid, 1);
        g_clear = 1'b1;
        @(posedge clk); #1;
        g_clear = 1'b0;
        check("t5_cleared", g_m_valid, 0);
        g_m_ready = 1'b1;
        drain();
        check("t5_no_crc", g_out_q.size(), 0);
        pay.delete();
        pay.push_back(8'($urandom));
        pay.push_back(8'($urandom));
        send(0, pay[0], 1'b0);
        send(0, pay[1], 1'b1);
        g_exp_q.push_back({1'b0, pay[0]});
        g_exp_q.push_back({1'b0, pay[1]});
        g_exp_q.push_back({1'b1, ref_crc(8'h00, pay)});
        drain();
        g_compare("t5");

        // Saturate err_cnt with a stream of bad one-beat frames
        c_s_valid = 1'b1; c_s_last = 1'b1; c_s_data = 8'h01;
        repeat (16'hFFFC - exp_err) @(posedge clk);
        #1;
        c_s_valid = 1'b0;
        check("t6_cnt_fffc", c_err_cnt, 16'hFFFC);
        for (int k = 1; k <= 4; k++) begin
            send(2, 8'($urandom_range(1, 255)), 1'b1);
            check($sformatf("t6_err%0d", k), c_crc_err, 1);
            check($sformatf("t6_cnt%0d", k), c_err_cnt, (k >= 3) ? 16'hFFFF : 16'hFFFC + k);
        end

        // Asynchronous reset mid-frame, then a fresh frame
        g_mon_en = 1'b0;
        g_m_ready = 1'b0;
        send(0, 8'h5A, 1'b0);
        check("t7_pending", g_m_valid, 1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("t7_m_valid", g_m_valid, 0);
        check("t7_m_data", g_m_data, 0);
        check("t7_m_last", g_m_last, 0);
        check("t7_err_cnt", c_err_cnt, 0);
        check("t7_crc_done", c_crc_done, 0);
        check("t7_c_m_valid", c_m_valid, 0);
        @(negedge clk) rst_n = 1'b1;
        g_m_ready = 1'b1;
        g_out_q.delete();
        g_exp_q.delete();
        @(posedge clk); #1;
        g_mon_en = 1'b1;
        send(0, 8'h01, 1'b1);
        g_exp_q.push_back(9'h001);
        g_exp_q.push_back(9'h131);
        drain();
        g_compare("t7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
